uart_rx_deser_cfg: RTL
======================

// Module: uart_rx_deser_cfg
// PURPOSE
//   Parametrised UART RX deserializer. Captures one sampled bit per bit period
//   at the mid-bit sample point and assembles a data word of run-time length
//   (5..DATA_W bits), either LSB-first or MSB-first. Sits between the RX
//   edge/bit counters and data sampler and the RX FSM. Outputs a
//   right-aligned word plus a one-cycle done pulse.
// PARAMETERS
//   DATA_W      8   max data bits per frame; legal range 5..16
//   PRESCALE_W  6   width of edge_cnt and prescale
// PORTS
//   clk          in   1           RX oversampling clock
//   rst          in   1           reset, asynchronous, active-low
//   en           in   1           deserialize enable from RX FSM (data state)
//   sampled_bit  in   1           majority-voted bit from data sampler
//   edge_cnt     in   PRESCALE_W  oversample edge counter within bit period
//   prescale     in   PRESCALE_W  oversampling ratio (8/16/32)
//   data_len     in   5           frame data bits; clamped to [5, DATA_W]
//   msb_first    in   1           0: LSB-first (UART std); 1: MSB-first
//   p_data       out  DATA_W      assembled word, right-aligned, zero-extended
//   data_done    out  1           1-cycle pulse: p_data updated this cycle
//   bit_idx      out  5           bits captured so far in current frame
// BEHAVIOUR
//   - Reset: p_data=0, data_done=0, bit_idx=0. Shift reg and latched config
//     are also cleared.
//   - Sample point: sp = (prescale>>1)+2, computed PRESCALE_W+1 bits wide.
//     strobe = en && (edge_cnt == sp). One strobe per bit period max.
//   - Config latch: on a strobe with bit_idx==0, latch len_q = clamp(data_len)
//     and dir_q = msb_first. Both are held until frame end or abort.
//     Mid-frame changes to data_len/msb_first are ignored.
//   - Shift on strobe:
//     LSB-first: sh <= {sampled_bit, sh[DATA_W-1:1]}.
//     MSB-first: sh <= {sh[DATA_W-2:0], sampled_bit}.
//     bit_idx increments by 1.
//   - Frame end: a strobe with bit_idx == len_q-1 completes the frame. On the
//     following clk edge:
//     p_data <= LSB-first ? (sh_next >> (DATA_W-len_q)) : (sh_next & mask(len_q)).
//     data_done=1 for exactly one cycle; bit_idx=0.
//     Latency: strobe edge -> p_data/data_done valid 1 cycle later.
//   - Back-to-back frames: a strobe in the cycle after done starts a new frame.
//     No dead cycle is required.
//   - Abort: en low with bit_idx!=0 clears bit_idx and sh next edge.
//     p_data holds its last completed value; no data_done.
//   - p_data changes only with data_done. Otherwise it holds.
//   - en low, idle: all state holds. edge_cnt values other than sp are ignored.
//   - Reset asserted mid-frame: immediate clear to reset values. No done pulse.
//   - Clamp: data_len<5 -> 5; data_len>DATA_W -> DATA_W.
// CONFIGURATION
//   DESER_PARITY_EN defined:
//     - Adds output par_calc (1 bit). Reset value 0.
//     - par_calc is the XOR of all len_q captured bits.
//     - par_calc updates on the same edge as data_done and holds otherwise.
//     - The running parity accumulator clears on frame end and on abort.
//   DESER_PARITY_EN undefined: no par_calc port and no parity logic.
//     All other behaviour is identical.
// TESTING
//   1. prescale=8 (sp=6), len=8, LSB-first, bits 1,0,1,0,0,1,0,1
//      -> p_data=0xA5, one data_done pulse 1 clk after 8th strobe.
//   2. Same bits, msb_first=1 -> p_data=0xA5 reversed =0xA5? use bits
//      1,1,0,0,0,0,0,1 -> p_data=0xC1. LSB-first with same bits -> 0x83.
//   3. len=5, LSB-first, bits 1,1,0,1,0 -> p_data=0x0B after 5th strobe;
//      bits [7:5]=0.
//   4. Abort: en low after 3 strobes -> bit_idx=0, p_data unchanged, no done.
//      Next full frame of 0x3C -> p_data=0x3C.
//   5. data_len=3 -> treated as 5; data_len=12 with DATA_W=8 -> treated as 8.
//      data_len changed mid-frame from 8 to 5 -> frame still 8 bits.
//   6. DESER_PARITY_EN, frame 0xA5 -> par_calc=0; frame 0xA4 -> par_calc=1.
//      rst low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_deser_cfg.sv
// uart_rx_deser_cfg -- UART RX deserializer with run-time frame length and
// bit order. One bit is captured per bit period at the mid-bit sample point
// and the finished word is presented right-aligned with a one-cycle done pulse.
// Optional feature macro: DESER_PARITY_EN adds the par_calc output (XOR of
// all captured data bits of the last completed frame).
module uart_rx_deser_cfg #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sampled_bit,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [4:0]            data_len,
  input  logic                  msb_first,
  output logic [DATA_W-1:0]     p_data,
  output logic                  data_done,
`ifdef DESER_PARITY_EN
  output logic                  par_calc,
`endif
  output logic [4:0]            bit_idx
);

  localparam logic [4:0] MIN_LEN = 5'd5;
  localparam logic [4:0] MAX_LEN = 5'(DATA_W);

  // Limit the requested frame length to what the shift register can hold.
  function automatic logic [4:0] clamp_len(input logic [4:0] l);
    logic [4:0] r;
    r = l;
    if (l < MIN_LEN) r = MIN_LEN;
    if (l > MAX_LEN) r = MAX_LEN;
    return r;
  endfunction

  // Low l bits set; used to right-align MSB-first words.
  function automatic logic [DATA_W-1:0] len_mask(input logic [4:0] l);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (5'(i) < l);
    return m;
  endfunction

  logic [DATA_W-1:0]   sh;
  logic [DATA_W-1:0]   sh_next;
  logic [DATA_W-1:0]   word_next;
  logic [4:0]          len_q;
  logic                dir_q;
  logic [4:0]          len_eff;
  logic                dir_eff;
  logic [4:0]          shamt;
  logic [PRESCALE_W:0] sp;
  logic                strobe;
  logic                first;
  logic                last;

  // Sample-point strobe, effective frame config and next shift-register value.
  // On the first bit of a frame the config is not latched yet, so the live
  // inputs steer that bit.
  always_comb begin
    sp      = {1'b0, prescale >> 1} + (PRESCALE_W+1)'(2);
    strobe  = en && ({1'b0, edge_cnt} == sp);
    first   = (bit_idx == 5'd0);
    len_eff = first ? clamp_len(data_len) : len_q;
    dir_eff = first ? msb_first : dir_q;
    sh_next = dir_eff ? {sh[DATA_W-2:0], sampled_bit}
                      : {sampled_bit, sh[DATA_W-1:1]};
    last    = strobe && (bit_idx == len_eff - 5'd1);
    shamt   = MAX_LEN - len_eff;
    word_next = dir_eff ? (sh_next & len_mask(len_eff)) : (sh_next >> shamt);
  end

  // Frame assembly: latch config on the first bit, shift on every strobe,
  // publish the word on the last bit, and drop a partial frame when en falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh        <= '0;
      len_q     <= MIN_LEN;
      dir_q     <= 1'b0;
      bit_idx   <= 5'd0;
      p_data    <= '0;
      data_done <= 1'b0;
    end else begin
      data_done <= 1'b0;
      if (strobe) begin
        if (first) begin
          len_q <= len_eff;
          dir_q <= msb_first;
        end
        if (last) begin
          p_data    <= word_next;
          data_done <= 1'b1;
          bit_idx   <= 5'd0;
          sh        <= '0;
        end else begin
          sh      <= sh_next;
          bit_idx <= bit_idx + 5'd1;
        end
      end else if (!en && !first) begin
        sh      <= '0;
        bit_idx <= 5'd0;
      end
    end
  end

`ifdef DESER_PARITY_EN
  logic par_acc;

  // Running parity of captured bits; published alongside data_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_acc  <= 1'b0;
      par_calc <= 1'b0;
    end else begin
      if (strobe) begin
        if (last) begin
          par_calc <= par_acc ^ sampled_bit;
          par_acc  <= 1'b0;
        end else begin
          par_acc <= par_acc ^ sampled_bit;
        end
      end else if (!en && !first) begin
        par_acc <= 1'b0;
      end
    end
  end
`endif

endmodule
